// File: rtl/ekf_seq_fusion.sv
// Sequential N-sensor diagonal EKF fusion stage.
// Each state element is folded over the enabled channels one pair at a time:
//   X = (Pn*Xa + Pa*Xn) / (Pa + Pn),  P = Pa*Pn / (Pa + Pn)
// using one pair of restoring dividers shared by every step.
// Handshake: a frame transfers on the input side when in_valid && in_ready,
// and on the output side when out_valid && out_ready; a producer holds valid
// and data until the transfer edge, and neither ready depends on valid.
module ekf_seq_fusion #(
  parameter int W         = 16,
  parameter int N_SENS    = 3,
  parameter int STATE_DIM = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_SENS-1:0]             ch_en,
  input  logic [N_SENS*STATE_DIM*W-1:0] x_in,
  input  logic [N_SENS*STATE_DIM*W-1:0] p_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [STATE_DIM*W-1:0]        xf_out,
  output logic [STATE_DIM*W-1:0]        pf_out,
  output logic                          sat_flag,
  output logic                          dz_flag,
  output logic                          no_meas
);

  localparam int QW  = 2*W + 1;  // dividend / quotient width and iteration count
  localparam int NW  = 2*W + 2;  // signed numerator width
  localparam int PW  = 2*W;      // variance product width
  localparam int DW  = W + 1;    // denominator and remainder width
  localparam int RW  = W + 2;    // trial remainder width
  localparam int XCW = QW + 1;   // signed candidate before clipping
  localparam int EW  = (STATE_DIM > 1) ? $clog2(STATE_DIM) : 1;
  localparam int CW  = (N_SENS > 1) ? $clog2(N_SENS) : 1;
  localparam int KW  = $clog2(QW);
  localparam logic signed [XCW-1:0] X_MAX = XCW'(2**(W-1) - 1);
  localparam logic signed [XCW-1:0] X_MIN = -X_MAX - 1;

  // S_STEP decides skip / copy / fuse for one channel; when fusing it is the
  // multiply cycle that loads the dividers.
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STEP, S_DIV, S_WB, S_DONE} state_t;

  state_t state, st_nxt;

  logic signed [W-1:0] x_r [N_SENS][STATE_DIM];
  logic        [W-1:0] p_r [N_SENS][STATE_DIM];
  logic [N_SENS-1:0]   en_r;
  logic [EW-1:0]       e_idx;
  logic [CW-1:0]       c_idx;
  logic [KW-1:0]       it_cnt;
  logic signed [W-1:0] acc_x;
  logic        [W-1:0] acc_p;
  logic                acc_vld;
  logic signed [W-1:0] xw [STATE_DIM];
  logic        [W-1:0] pw [STATE_DIM];
  logic [QW-1:0]       xq, pq;
  logic [DW-1:0]       xr, pr, den_r;
  logic                x_neg;

  logic signed [W-1:0]   cur_x;
  logic        [W-1:0]   cur_p;
  logic                  cur_en, last_c, last_e, fuse_go, step_done;
  logic signed [NW-1:0]  xa_s, xn_s, pa_s, pn_s, num;
  logic [QW-1:0]         num_mag;
  logic [DW-1:0]         den;
  logic [PW-1:0]         pp;
  logic [RW-1:0]         x_trial, p_trial;
  logic                  x_ge, p_ge;
  logic [DW-1:0]         xr_nxt, pr_nxt;
  logic [QW-1:0]         xq_nxt, pq_nxt;
  logic signed [XCW-1:0] xa_ext, xn_ext, x_cand;
  logic signed [W-1:0]   new_x, elem_x;
  logic        [W-1:0]   new_p, elem_p;
  logic                  new_vld, set_sat, set_dz;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= st_nxt;
  end

  // Next-state logic.
  always_comb begin
    st_nxt = state;
    unique case (state)
      S_IDLE: if (in_valid && in_ready) st_nxt = S_LOAD;
      S_LOAD: st_nxt = S_STEP;
      S_STEP: begin
        if (fuse_go)               st_nxt = S_DIV;
        else if (last_c && last_e) st_nxt = S_DONE;
      end
      S_DIV:  if (it_cnt == KW'(QW - 1)) st_nxt = S_WB;
      S_WB:   st_nxt = (last_c && last_e) ? S_DONE : S_STEP;
      S_DONE: if (out_ready) st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are registered images of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (st_nxt == S_IDLE);
      out_valid <= (st_nxt == S_DONE);
    end
  end

  // Current sample selection, step classification and multiply-cycle operands.
  always_comb begin
    cur_x     = x_r[c_idx][e_idx];
    cur_p     = p_r[c_idx][e_idx];
    cur_en    = en_r[c_idx];
    last_c    = (c_idx == CW'(N_SENS - 1));
    last_e    = (e_idx == EW'(STATE_DIM - 1));
    fuse_go   = (state == S_STEP) && cur_en && acc_vld;
    step_done = ((state == S_STEP) && !fuse_go) || (state == S_WB);
    xa_s      = NW'(acc_x);
    xn_s      = NW'(cur_x);
    pa_s      = NW'(acc_p);
    pn_s      = NW'(cur_p);
    num       = pn_s * xa_s + pa_s * xn_s;
    num_mag   = num[NW-1] ? QW'(-num) : QW'(num);
    den       = {1'b0, acc_p} + {1'b0, cur_p};
    pp        = PW'(acc_p) * PW'(cur_p);
  end

  // One restoring iteration of each divider (quotient bit shifts in at the LSB).
  always_comb begin
    x_trial = {xr, xq[QW-1]};
    x_ge    = (x_trial >= {1'b0, den_r});
    xr_nxt  = x_ge ? DW'(x_trial - {1'b0, den_r}) : x_trial[DW-1:0];
    xq_nxt  = {xq[QW-2:0], x_ge};
    p_trial = {pr, pq[QW-1]};
    p_ge    = (p_trial >= {1'b0, den_r});
    pr_nxt  = p_ge ? DW'(p_trial - {1'b0, den_r}) : p_trial[DW-1:0];
    pq_nxt  = {pq[QW-2:0], p_ge};
  end

  // Accumulator update at the end of a step, and the element write-back value.
  always_comb begin
    new_x   = acc_x;
    new_p   = acc_p;
    new_vld = acc_vld;
    set_sat = 1'b0;
    set_dz  = 1'b0;
    xa_ext  = XCW'(acc_x);
    xn_ext  = XCW'(cur_x);
    x_cand  = '0;
    if ((state == S_STEP) && cur_en && !acc_vld) begin
      new_x   = cur_x;
      new_p   = cur_p;
      new_vld = 1'b1;
    end
    if (state == S_WB) begin
      if (den_r == '0) begin
        // Both variances zero: plain midpoint, zero variance.
        x_cand = (xa_ext + xn_ext) >>> 1;
        new_p  = '0;
        set_dz = 1'b1;
      end else begin
        x_cand = x_neg ? -signed'({1'b0, xq}) : signed'({1'b0, xq});
        new_p  = (|pq[QW-1:W]) ? '1 : pq[W-1:0];
      end
      if (x_cand > X_MAX) begin
        new_x   = X_MAX[W-1:0];
        set_sat = 1'b1;
      end else if (x_cand < X_MIN) begin
        new_x   = X_MIN[W-1:0];
        set_sat = 1'b1;
      end else begin
        new_x = x_cand[W-1:0];
      end
    end
    elem_x = new_vld ? new_x : '0;
    elem_p = new_vld ? new_p : '1;
  end

  // Frame capture, step sequencing, divider iterations and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_SENS; c++) begin
        for (int e = 0; e < STATE_DIM; e++) begin
          x_r[c][e] <= '0;
          p_r[c][e] <= '0;
        end
      end
      for (int e = 0; e < STATE_DIM; e++) begin
        xw[e] <= '0;
        pw[e] <= '0;
      end
      en_r     <= '0;
      e_idx    <= '0;
      c_idx    <= '0;
      it_cnt   <= '0;
      acc_x    <= '0;
      acc_p    <= '0;
      acc_vld  <= 1'b0;
      xq       <= '0;
      pq       <= '0;
      xr       <= '0;
      pr       <= '0;
      den_r    <= '0;
      x_neg    <= 1'b0;
      xf_out   <= '0;
      pf_out   <= '0;
      sat_flag <= 1'b0;
      dz_flag  <= 1'b0;
      no_meas  <= 1'b0;
    end else begin
      if ((state == S_IDLE) && in_valid && in_ready) begin
        for (int c = 0; c < N_SENS; c++) begin
          for (int e = 0; e < STATE_DIM; e++) begin
            x_r[c][e] <= x_in[(c*STATE_DIM + e)*W +: W];
            p_r[c][e] <= p_in[(c*STATE_DIM + e)*W +: W];
          end
        end
        en_r     <= ch_en;
        sat_flag <= 1'b0;
        dz_flag  <= 1'b0;
        no_meas  <= 1'b0;
      end
      if (state == S_LOAD) begin
        e_idx   <= '0;
        c_idx   <= '0;
        acc_vld <= 1'b0;
      end
      if (fuse_go) begin
        xq     <= num_mag;
        x_neg  <= num[NW-1];
        xr     <= '0;
        pq     <= QW'(pp);
        pr     <= '0;
        den_r  <= den;
        it_cnt <= '0;
      end
      if (state == S_DIV) begin
        xq     <= xq_nxt;
        xr     <= xr_nxt;
        pq     <= pq_nxt;
        pr     <= pr_nxt;
        it_cnt <= it_cnt + 1'b1;
      end
      if (step_done) begin
        acc_x   <= new_x;
        acc_p   <= new_p;
        acc_vld <= new_vld;
        if (set_sat) sat_flag <= 1'b1;
        if (set_dz)  dz_flag  <= 1'b1;
        if (last_c) begin
          xw[e_idx] <= elem_x;
          pw[e_idx] <= elem_p;
          if (!new_vld) no_meas <= 1'b1;
          acc_vld <= 1'b0;
          c_idx   <= '0;
          if (last_e) begin
            // Publish the whole frame at once so outputs only change on entering DONE.
            for (int k = 0; k < STATE_DIM; k++) begin
              xf_out[k*W +: W] <= (EW'(k) == e_idx) ? elem_x : xw[k];
              pf_out[k*W +: W] <= (EW'(k) == e_idx) ? elem_p : pw[k];
            end
          end else begin
            e_idx <= e_idx + 1'b1;
          end
        end else begin
          c_idx <= c_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/ekf_seq_fusion.md
Name: ekf_seq_fusion

Overview:
- Parametrised, sequential successor to the fixed two-sensor EKF fusion stage.
- Fuses N_SENS per-sensor diagonal state estimates (x, p) for STATE_DIM state elements into one fused estimate.
- Fusion is pairwise and sequential per element using X = (Pn·Xa + Pa·Xn)/(Pa+Pn) and P = Pa·Pn/(Pa+Pn), computed on one shared iterative divider pair.
- Sits between the per-sensor measurement units and the track output stage. Valid/ready handshake on both sides; per-channel enable mask.

Parameters:
- W, 16, data width of x (signed) and p (unsigned variance).
- N_SENS, 3, number of sensor channels (≥1).
- STATE_DIM, 6, number of state elements.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input frame valid.
- in_ready  output  1  block idle, can accept a frame.
- ch_en  input  N_SENS  per-channel enable; bit c enables channel c.
- x_in  input  N_SENS*STATE_DIM*W  signed states; channel c, element e at [(c*STATE_DIM+e)*W +: W].
- p_in  input  N_SENS*STATE_DIM*W  unsigned variances, same packing.
- out_valid  output  1  fused frame valid.
- out_ready  input  1  consumer accepts.
- xf_out  output  STATE_DIM*W  fused signed states; element e at [e*W +: W].
- pf_out  output  STATE_DIM*W  fused unsigned variances, same packing.
- sat_flag  output  1  some X was clipped this frame.
- dz_flag  output  1  some fusion step had Pa+Pn==0.
- no_meas  output  1  ch_en was all zero.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0, out_valid=0; xf_out, pf_out and all flags =0. First rising edge after rst_n=1 sets in_ready=1. Reset mid-frame discards all work; no partial output.
- Accept on in_valid&&in_ready. x_in, p_in and ch_en are captured into internal registers in that cycle. in_ready drops next cycle. Flags are cleared at accept.
- States: IDLE → LOAD (1 cycle) → per element e=0..STATE_DIM-1, per channel c=0..N_SENS-1 one step → DONE.
- Step costs:
  - ch_en[c]=0: SKIP, 1 cycle.
  - Enabled and accumulator empty: COPY, 1 cycle; Xa=x, Pa=p.
  - Otherwise: FUSE, 2W+3 cycles = MUL 1, DIV 2W+1, WB 1.
- The accumulator resets to empty at each element start.
- After the last channel, (Xa, Pa) is written into xf_out/pf_out element e. Empty accumulator writes X=0, P=2^W-1 and sets no_meas.
- Latency: out_valid rises 1 + Σ(step costs) cycles after the accept edge.
  - Example, W=16: all three channels enabled → 1+6·(1+35+35)=427.
- FUSE arithmetic:
  - Numerator Pn·Xa + Pa·Xn is signed, 2W+2 bits. Denominator Pa+Pn is W+1 bits unsigned.
  - Pa·Pn is unsigned, 2W bits.
  - Two sign-magnitude restoring dividers run concurrently, one quotient bit per cycle, 2W+1 iterations.
  - Quotients truncate toward zero.
  - X is clipped to [−2^(W−1), 2^(W−1)−1]; clipping sets sat_flag. P always fits in W.
- Zero denominator (Pa=Pn=0): X=(Xa+Xn)>>>1 (arithmetic, W+1-bit sum), P=0, dz_flag=1. Cycle count is unchanged.
- DONE: out_valid=1. Outputs and flags are held stable until out_valid&&out_ready. Next cycle: out_valid=0, in_ready=1, state IDLE.
- Outputs retain their last values after handshake until the next DONE. in_valid is ignored while in_ready=0.

Test Plan:
- W=16, N=3, D=6. ch_en=011; all elements x0=100,p0=40,x1=200,p1=40 → xf=150, pf=20 every element, flags 0, out_valid 223 cycles after accept.
- ch_en=111; x=(300,0,−300), p=(10,10,10) → step1 X=150,P=5; final xf=0, pf=3; latency 427.
- ch_en=011; x0=−7,p0=1,x1=0,p1=1 → xf=−3 (toward zero), pf=0, dz_flag=0.
- ch_en=011; p0=p1=0, x0=10, x1=−4 → xf=3, pf=0, dz_flag=1.
- ch_en=000 → xf=0, pf=0xFFFF all elements, no_meas=1, latency 19.
- Hold out_ready=0 for 100 cycles after DONE → outputs stable, in_ready=0. Then drop rst_n mid-fuse of the next frame → out_valid=0, in_ready=0 immediately. in_ready=1 one edge after release; a fresh frame yields correct results.
